operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 18 +
 rtl/operand_fetch_regfile.sv | 43 ++++
 rtl/operand_fetch.sv | 137 +++++++++++++
 tb/tb_operand_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
//   Shared constants for the operand-fetch slice: default operand width,
//   default register count, register-address width and the ALU opcode set.
package operand_fetch_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_NREG   = 8;
    localparam int unsigned REG_ADDR_W = $clog2(DEF_NREG);

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

endpackage

// File: rtl/operand_fetch_regfile.sv
// regfile
//   NREG x DATA_W register file, register 0 hardwired to zero.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset (clears all)
//     ra_addr / ra_data   asynchronous read port A
//     rb_addr / rb_data   asynchronous read port B
//     we, wa_addr, wa_data synchronous write port (writes to 0 discarded)
module regfile
    import operand_fetch_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned NREG   = DEF_NREG,
    localparam int unsigned AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [AW-1:0]     wa_addr,
    input  logic [DATA_W-1:0] wa_data
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa_addr != '0) begin
            mem[wa_addr] <= wa_data;
        end
    end

    always_comb begin
        ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
        rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
//   Reads ALU operands from the register file, tracks outstanding writes
//   with a per-register pending scoreboard, stalls the decoder on hazards
//   and registers operands/control towards the ALU (one-cycle latency).
//   Optional build macro OPERAND_FETCH_BYPASS_EN: a source being written
//   back this cycle takes wb_data directly instead of stalling.
//   Ports:
//     clk, reset                  clock, asynchronous active-high reset
//     in_valid / in_ready         decoder handshake (ready is combinational)
//     in_rs, in_rt, in_rd         source A, source B, destination addresses
//     in_ctrl                     ALU opcode, passed through
//     in_use_imm, in_imm          select immediate for operand B
//     in_wen                      instruction writes in_rd
//     wb_en, wb_addr, wb_data     writeback port
//     out_valid, out_ctrl, out_a, out_b, out_rd, out_wen   registered to ALU
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned NREG   = DEF_NREG,
    localparam int unsigned AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic [AW-1:0]     in_rd,
    input  logic [2:0]        in_ctrl,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_wen,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    output logic [2:0]        out_ctrl,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [AW-1:0]     out_rd,
    output logic              out_wen
);

    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              wb_hit_a;
    logic              wb_hit_b;
    logic              haz_a;
    logic              haz_b;
    logic              accept;
    alu_op_e           ctrl_q;

    regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (in_rs),
        .ra_data (rf_a),
        .rb_addr (in_rt),
        .rb_data (rf_b),
        .we      (wb_en),
        .wa_addr (wb_addr),
        .wa_data (wb_data)
    );

    // Hazard / operand selection. A writeback hitting a source either
    // forwards (bypass build) or forces a one-cycle stall so the source
    // is read from the updated register file next cycle.
    always_comb begin
        wb_hit_a = wb_en && (wb_addr == in_rs) && (in_rs != '0);
        wb_hit_b = wb_en && (wb_addr == in_rt) && (in_rt != '0);
`ifdef OPERAND_FETCH_BYPASS_EN
        haz_a = pending[in_rs] && !wb_hit_a;
        haz_b = pending[in_rt] && !wb_hit_b;
        src_a = wb_hit_a ? wb_data : rf_a;
        src_b = wb_hit_b ? wb_data : rf_b;
`else
        haz_a = pending[in_rs] || wb_hit_a;
        haz_b = pending[in_rt] || wb_hit_b;
        src_a = rf_a;
        src_b = rf_b;
`endif
        in_ready = !(haz_a || (!in_use_imm && haz_b));
        accept   = in_valid && in_ready;
    end

    // Clear before set, so a same-cycle reservation of the written
    // register leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (accept && in_wen && in_rd != '0) begin
            pending_nxt[in_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            ctrl_q    <= ALU_AND;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                ctrl_q  <= alu_op_e'(in_ctrl);
                out_a   <= src_a;
                out_b   <= in_use_imm ? in_imm : src_b;
                out_rd  <= in_rd;
                out_wen <= in_wen;
            end
        end
    end

    assign out_ctrl = ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 8;
`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_rs, in_rt, in_rd, in_ctrl;
    logic          in_use_imm;
    logic [DW-1:0] in_imm;
    logic          in_wen;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic [2:0]    out_ctrl;
    logic [DW-1:0] out_a, out_b;
    logic [2:0]    out_rd;
    logic          out_wen;

    operand_fetch #(.DATA_W(DW), .NREG(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_ctrl    (in_ctrl),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .in_wen     (in_wen),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ctrl   (out_ctrl),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .out_wen    (out_wen)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model: architectural register values, reservation flags,
    // and the values the ALU side should currently be showing.
    logic [DW-1:0] m_reg [NR];
    bit            m_pend [NR];
    bit            e_valid;
    logic [2:0]    e_ctrl;
    logic [DW-1:0] e_a, e_b;
    logic [2:0]    e_rd;
    bit            e_wen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        e_valid = 0; e_ctrl = '0; e_a = '0; e_b = '0; e_rd = '0; e_wen = 0;
    endtask

    function automatic bit written_now(input logic [2:0] r);
        return wb_en && wb_addr == r && r != 3'd0;
    endfunction

    // A source may be read if nothing will still be outstanding for it:
    // with forwarding the in-flight writeback satisfies a reservation,
    // without it a register being written this cycle must wait a cycle.
    function automatic bit blocked(input logic [2:0] r);
        if (r == 3'd0) return 1'b0;
        if (BYPASS) return m_pend[r] && !written_now(r);
        return m_pend[r] || written_now(r);
    endfunction

    function automatic logic [DW-1:0] value_of(input logic [2:0] r);
        if (r == 3'd0) return '0;
        if (BYPASS && written_now(r)) return wb_data;
        return m_reg[r];
    endfunction

    function automatic bit m_ready();
        return !(blocked(in_rs) || (!in_use_imm && blocked(in_rt)));
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, "_valid"}, out_valid, e_valid);
        check({pfx, "_ctrl"},  out_ctrl,  e_ctrl);
        check({pfx, "_a"},     out_a,     e_a);
        check({pfx, "_b"},     out_b,     e_b);
        check({pfx, "_rd"},    out_rd,    e_rd);
        check({pfx, "_wen"},   out_wen,   e_wen);
    endtask

    // One cycle: check ready against the model, clock, advance the model,
    // check the registered outputs.
    task automatic step();
        bit            rdy, acc;
        logic [DW-1:0] na, nb;
        #1;
        rdy = m_ready();
        check("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        na  = value_of(in_rs);
        nb  = in_use_imm ? in_imm : value_of(in_rt);
        @(posedge clk);
        #1;
        e_valid = acc;
        if (acc) begin
            e_ctrl = in_ctrl; e_a = na; e_b = nb; e_rd = in_rd; e_wen = in_wen;
        end
        if (wb_en && wb_addr != 3'd0) begin
            m_reg[wb_addr]  = wb_data;
            m_pend[wb_addr] = 1'b0;
        end
        if (acc && in_wen && in_rd != 3'd0) m_pend[in_rd] = 1'b1;
        check_outputs("out");
    endtask

    task automatic idle();
        in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_ctrl = 0;
        in_use_imm = 0; in_imm = 0; in_wen = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                         input logic [2:0] ctrl, input bit use_imm, input logic [DW-1:0] imm,
                         input bit wen);
        in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_ctrl = ctrl;
        in_use_imm = use_imm; in_imm = imm; in_wen = wen;
    endtask

    task automatic wb(input logic [2:0] a, input logic [DW-1:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    task automatic nowb();
        wb_en = 0;
    endtask

    initial begin
        logic [2:0] ops [5];
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2; ops[3] = 3'd6; ops[4] = 3'd7;

        // Reset state
        idle();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst");
        reset = 0;
        #1;
        check("rst_ready", in_ready, 1);

        // Basic add after two writebacks
        wb(3'd1, 8'h05); step();
        wb(3'd2, 8'h03); step();
        nowb();
        issue(3'd1, 3'd2, 3'd3, 3'd2, 0, 8'h00, 1); step();
        check("add_a", out_a, 8'h05);
        check("add_b", out_b, 8'h03);
        check("add_ctrl", out_ctrl, 3'd2);
        check("add_rd", out_rd, 3'd3);
        idle(); wb(3'd3, 8'h08); step();

        // RAW hazard on r4 resolved by writeback
        idle();
        issue(3'd0, 3'd0, 3'd4, 3'd1, 1, 8'h01, 1); step();
        issue(3'd4, 3'd0, 3'd0, 3'd0, 1, 8'h00, 0);
        #1 check("raw_stall", in_ready, 0);
        step(); step();
        wb(3'd4, 8'hA5); step();
        nowb(); step();
        check("raw_a", out_a, 8'hA5);
        idle(); step();

        // Writeback and read of r5 in the same cycle
        issue(3'd5, 3'd0, 3'd0, 3'd2, 1, 8'h00, 0);
        wb(3'd5, 8'h7F); step();
        nowb(); step();
        check("wbrd_a", out_a, 8'h7F);
        idle(); step();

        // r0 is immutable and never stalls
        wb(3'd0, 8'hFF); step();
        nowb();
        issue(3'd0, 3'd0, 3'd0, 3'd1, 1, 8'h10, 0);
        #1 check("r0_ready", in_ready, 1);
        step();
        check("r0_a", out_a, 8'h00);
        check("r0_b", out_b, 8'h10);
        idle(); step();

        // Same-cycle writeback and reservation of r6: reservation survives
        issue(3'd0, 3'd0, 3'd6, 3'd2, 1, 8'h02, 1);
        wb(3'd6, 8'h33); step();
        nowb();
        issue(3'd6, 3'd0, 3'd0, 3'd2, 1, 8'h00, 0);
        #1 check("setwin_stall", in_ready, 0);
        step();
        idle(); wb(3'd6, 8'h44); step();
        nowb(); step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0] pick;
            in_valid   = ($urandom_range(0, 3) != 0);
            in_rs      = 3'($urandom_range(0, 7));
            in_rt      = 3'($urandom_range(0, 7));
            in_rd      = 3'($urandom_range(0, 7));
            in_ctrl    = ops[$urandom_range(0, 4)];
            in_use_imm = $urandom_range(0, 1) == 1;
            in_imm     = 8'($urandom);
            in_wen     = $urandom_range(0, 1) == 1;
            wb_en      = $urandom_range(0, 1) == 1;
            pick       = 3'($urandom_range(0, 7));
            for (int k = 0; k < int'(NR); k++) begin
                if (m_pend[(int'(pick) + k) % int'(NR)] && $urandom_range(0, 3) != 0) begin
                    pick = 3'((int'(pick) + k) % int'(NR));
                    break;
                end
            end
            wb_addr = pick;
            wb_data = 8'($urandom);
            step();
        end

        // Reset while r2 is reserved and an output is in flight
        idle();
        wb(3'd2, 8'h00); step();
        nowb();
        issue(3'd0, 3'd0, 3'd2, 3'd6, 1, 8'h09, 1); step();
        check("pre_rst_valid", out_valid, 1);
        idle();
        #2 reset = 1;
        model_reset();
        #1;
        check_outputs("midrst");
        check("midrst_ready", in_ready, 1);
        @(posedge clk);
        #2 reset = 0;
        issue(3'd2, 3'd2, 3'd0, 3'd0, 0, 8'h00, 0);
        #1 check("postrst_ready", in_ready, 1);
        step();
        check("postrst_a", out_a, 8'h00);
        idle(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
